seg7_scan_driver: RTL

Four-digit multiplexed seven-segment display driver for the vending-machine front panel. It sits directly downstream of the 1 kHz clock divider and consumes its `slow_clock` output as the digit-scan timebase. A binary amount (credit or price, 0–9999) is converted to BCD by a sequential double-dabble engine. The BCD digits are then scanned onto common-anode displays, with optional leading-zero blanking and a blink mode.

---
 rtl/seg7_scan_driver.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed common-anode 7-segment driver: sequential double-dabble
// binary-to-BCD conversion, digit scanning, leading-zero blanking and blink.
module seg7_scan_driver #(
  parameter int VALUE_W   = 14,
  parameter int BLINK_DIV = 250
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               scan_clk,
  input  logic [VALUE_W-1:0] value,
  input  logic               load,
  input  logic               blank_lz,
  input  logic               blink_en,
  output logic               busy,
  output logic [3:0]         an,
  output logic [6:0]         seg,
  output logic               dp
);

  localparam int ITER_W = $clog2(VALUE_W + 1);
  localparam int BLK_W  = $clog2(BLINK_DIV + 1);
  localparam logic [31:0] MAX_VAL = 32'd9999;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_COMMIT  = 2'd2
  } state_t;

  function automatic logic [15:0] bcd_adjust(input logic [15:0] b);
    logic [15:0] r;
    r = b;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = (b[4*i +: 4] >= 4'd5) ? (b[4*i +: 4] + 4'd3) : b[4*i +: 4];
    end
    return r;
  endfunction

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  state_t             state_r;
  logic [VALUE_W-1:0] bin_r;
  logic [15:0]        bcd_r;
  logic [15:0]        disp_r;
  logic [ITER_W-1:0]  iter_r;
  logic               busy_r;
  logic               scan_prev_r;
  logic [1:0]         idx_r;
  logic [BLK_W-1:0]   blk_cnt_r;
  logic               blink_ph_r;
  logic [3:0]         an_r;
  logic [6:0]         seg_r;
  logic               dp_r;

  logic               tick_s;
  logic [15:0]        bcd_adj_s;
  logic [VALUE_W-1:0] value_sat_s;
  logic [3:0]         digit_s;
  logic               blank_s;
  logic               lz1_s, lz2_s, lz3_s;
  logic [3:0]         an_next_s;
  logic [6:0]         seg_next_s;

  assign tick_s      = scan_clk & ~scan_prev_r;
  assign bcd_adj_s   = bcd_adjust(bcd_r);
  assign value_sat_s = (32'(value) > MAX_VAL) ? VALUE_W'(MAX_VAL) : value;

  // Scan edge detection and digit index
  always_ff @(posedge clk) begin
    if (!reset) begin
      scan_prev_r <= 1'b0;
      idx_r       <= 2'd0;
    end else begin
      scan_prev_r <= scan_clk;
      if (tick_s) idx_r <= idx_r + 2'd1;
      else        idx_r <= idx_r;
    end
  end

  // Blink phase: toggles every BLINK_DIV scan ticks, parked at zero when disabled
  always_ff @(posedge clk) begin
    if (!reset || !blink_en) begin
      blk_cnt_r  <= '0;
      blink_ph_r <= 1'b0;
    end else if (tick_s) begin
      if (blk_cnt_r == BLK_W'(BLINK_DIV - 1)) begin
        blk_cnt_r  <= '0;
        blink_ph_r <= ~blink_ph_r;
      end else begin
        blk_cnt_r  <= blk_cnt_r + BLK_W'(1);
        blink_ph_r <= blink_ph_r;
      end
    end else begin
      blk_cnt_r  <= blk_cnt_r;
      blink_ph_r <= blink_ph_r;
    end
  end

  // Converter FSM: capture, shift-add-3 iterations, atomic commit to disp_r
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      bin_r   <= '0;
      bcd_r   <= 16'h0000;
      disp_r  <= 16'h0000;
      iter_r  <= '0;
      busy_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (load) begin
            bin_r   <= value_sat_s;
            bcd_r   <= 16'h0000;
            iter_r  <= '0;
            busy_r  <= 1'b1;
            state_r <= ST_CONVERT;
          end
        end
        ST_CONVERT: begin
          {bcd_r, bin_r} <= {bcd_adj_s, bin_r} << 1;
          iter_r         <= iter_r + ITER_W'(1);
          if (iter_r == ITER_W'(VALUE_W - 1)) state_r <= ST_COMMIT;
        end
        ST_COMMIT: begin
          disp_r  <= bcd_r;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Next-digit selection, leading-zero blanking and blink gating
  always_comb begin
    lz3_s = (disp_r[15:12] == 4'd0);
    lz2_s = lz3_s & (disp_r[11:8] == 4'd0);
    lz1_s = lz2_s & (disp_r[7:4] == 4'd0);
    case (idx_r)
      2'd0:    begin digit_s = disp_r[3:0];   blank_s = 1'b0;  end
      2'd1:    begin digit_s = disp_r[7:4];   blank_s = lz1_s; end
      2'd2:    begin digit_s = disp_r[11:8];  blank_s = lz2_s; end
      2'd3:    begin digit_s = disp_r[15:12]; blank_s = lz3_s; end
      default: begin digit_s = 4'd0;          blank_s = 1'b0;  end
    endcase
    if (blank_lz && blank_s) seg_next_s = 7'h7F;
    else                     seg_next_s = seg_code(digit_s);
    if (blink_en && blink_ph_r) an_next_s = 4'hF;
    else                        an_next_s = ~(4'b0001 << idx_r);
  end

  // Registered display outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      an_r  <= 4'hF;
      seg_r <= 7'h7F;
      dp_r  <= 1'b1;
    end else begin
      an_r  <= an_next_s;
      seg_r <= seg_next_s;
      dp_r  <= 1'b1;
    end
  end

  assign busy = busy_r;
  assign an   = an_r;
  assign seg  = seg_r;
  assign dp   = dp_r;

endmodule
